// File: rtl/sha1_pkg.sv
// Shared SHA-1 padding constants, word type and padder state encoding.
package sha1_pkg;

    localparam int          SHA1_BLK_WORDS   = 16;
    localparam int          SHA1_LEN_WORD_HI = 14;
    localparam logic [31:0] SHA1_PAD_MARK    = 32'h8000_0000;

    typedef logic [31:0] sha1_word_t;

    typedef enum logic [2:0] {
        DATA,
        MARK,
        ZERO,
        LEN_HI,
        LEN_LO
    } pad_state_t;

    // Write byte b into big-endian lane 0..3 of w (lane 0 is bits 31:24).
    function automatic sha1_word_t put_byte(sha1_word_t w, logic [1:0] lane, logic [7:0] b);
        sha1_word_t r;
        r = w;
        r[{~lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/sha1_byte_packer.sv
// Big-endian byte-to-word packer with in-word 0x80 marker insertion and a
// one-entry output register that holds its word until downstream takes it.
module sha1_byte_packer
    import sha1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       beat_acc,   // beat handshake completed this cycle
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_empty,
    output logic       tail_fits,  // final beat: marker placed inside the emitted word
    output sha1_word_t pk_word,
    output logic       pk_valid,
    input  logic       pk_ready
);

    logic [1:0] byte_idx;
    sha1_word_t word_buf;

    logic       data_beat;
    logic       term;
    logic       full;
    logic       load;
    logic [2:0] fill_idx;
    sha1_word_t merged;

    // Merge the incoming byte and, on a final beat with room left, the marker.
    always_comb begin
        data_beat = beat_acc && !in_empty;
        term      = beat_acc && in_last;
        merged    = word_buf;
        if (data_beat) merged = put_byte(merged, byte_idx, in_data);
        fill_idx  = {1'b0, byte_idx} + {2'b00, data_beat};
        full      = fill_idx[2];
        // A terminator on an empty lane-0 word leaves the marker to the FSM.
        tail_fits = term && !full && (fill_idx[1:0] != 2'd0);
        if (tail_fits) merged = put_byte(merged, fill_idx[1:0], 8'h80);
        load      = full || tail_fits;
    end

    // Lane pointer, partial word and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx <= '0;
            word_buf <= '0;
            pk_word  <= '0;
            pk_valid <= 1'b0;
        end else begin
            if (load) begin
                pk_word  <= merged;
                pk_valid <= 1'b1;
            end else if (pk_ready) begin
                pk_valid <= 1'b0;
            end
            // Lanes below the fill point stay zero so the marker needs no masking.
            if (load || term) begin
                byte_idx <= '0;
                word_buf <= '0;
            end else if (data_beat) begin
                byte_idx <= byte_idx + 2'd1;
                word_buf <= merged;
            end
        end
    end

endmodule

// File: rtl/sha1_msg_padder.sv
// Streaming SHA-1 message padder: packs bytes into words, then appends the
// marker, zero fill and 64-bit bit length, emitting 16-word blocks.
// Optional feature macro: SHA1_PAD_LEN_OVF_EN (sticky bit-length overflow flag).
module sha1_msg_padder
    import sha1_pkg::*;
#(
    parameter int WORD_W        = 32,
    parameter int LEN_W         = 64,
    parameter int WORDS_PER_BLK = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_empty,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_blk_last,
    output logic              out_msg_last,
    output logic              len_ovf
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    localparam logic [IDX_W-1:0] IDX_BEFORE_LEN = IDX_W'(SHA1_LEN_WORD_HI - 1);
    localparam logic [IDX_W-1:0] IDX_BLK_LAST   = IDX_W'(WORDS_PER_BLK - 1);

    pad_state_t       state, state_nxt;
    logic [IDX_W-1:0] word_idx;
    logic [LEN_W-1:0] bit_cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             rdy_en;
    logic             beat_acc;
    logic             data_beat;
    logic             out_fire;
    logic             tail_fits;
    logic             pk_valid;
    sha1_word_t       pk_word;
    sha1_word_t       pad_word;
    logic [63:0]      len64;

    assign len64     = 64'(bit_cnt);
    assign in_ready  = rdy_en && (state == DATA) && !(pk_valid && !out_ready);
    assign beat_acc  = in_valid && in_ready;
    assign data_beat = beat_acc && !in_empty;
    // A packed data word always drains before any padding word is shown.
    assign out_valid    = pk_valid || (state != DATA);
    assign out_fire     = out_valid && out_ready;
    assign out_word     = pk_valid ? pk_word : pad_word;
    assign out_blk_last = out_valid && (word_idx == IDX_BLK_LAST);
    assign out_msg_last = (state == LEN_LO);

    sha1_byte_packer u_packer (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .beat_acc  (beat_acc),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .tail_fits (tail_fits),
        .pk_word   (pk_word),
        .pk_valid  (pk_valid),
        .pk_ready  (out_ready)
    );

    // Padding word selection and next-state decode.
    always_comb begin
        state_nxt = state;
        pad_word  = '0;
        unique case (state)
            DATA: begin
                if (beat_acc && in_last) state_nxt = tail_fits ? ZERO : MARK;
            end
            MARK: begin
                pad_word = SHA1_PAD_MARK;
                if (out_fire && !pk_valid)
                    state_nxt = (word_idx == IDX_BEFORE_LEN) ? LEN_HI : ZERO;
            end
            ZERO: begin
                // Also covers the packer's marker word, which drains first.
                if (out_fire && (word_idx == IDX_BEFORE_LEN)) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                pad_word = len64[63:32];
                if (out_fire) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                pad_word = len64[31:0];
                if (out_fire) state_nxt = DATA;
            end
            default: state_nxt = DATA;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= DATA;
        else         state <= state_nxt;
    end

    // Word position, message bit count and post-reset ready gate.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            word_idx <= '0;
            bit_cnt  <= '0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (out_fire) begin
                if (state == LEN_LO || word_idx == IDX_BLK_LAST) word_idx <= '0;
                else                                             word_idx <= word_idx + 1'b1;
            end
            if (out_fire && state == LEN_LO) bit_cnt <= '0;
            else if (data_beat)              bit_cnt <= cnt_nxt;
        end
    end

`ifdef SHA1_PAD_LEN_OVF_EN
    localparam int CW = LEN_W + 1;
    logic cnt_carry;
    logic ovf_q;

    assign {cnt_carry, cnt_nxt} = {1'b0, bit_cnt} + CW'(8);
    assign len_ovf = ovf_q;

    // Sticky overflow, held through the length words of the same message.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)                          ovf_q <= 1'b0;
        else if (out_fire && state == LEN_LO) ovf_q <= 1'b0;
        else if (data_beat && cnt_carry)      ovf_q <= 1'b1;
    end
`else
    assign cnt_nxt = bit_cnt + LEN_W'(8);
    assign len_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Scoreboard bench for sha1_msg_padder: a reference padder builds expected
// words from each message, a negedge monitor checks every output handshake.
module tb_sha1_msg_padder;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
    logic        in_ready;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_blk_last, out_msg_last, len_ovf;

    always #5 sys_clk = ~sys_clk;

    sha1_msg_padder dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_empty     (in_empty),
        .in_ready     (in_ready),
        .out_word     (out_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_blk_last (out_blk_last),
        .out_msg_last (out_msg_last),
        .len_ovf      (len_ovf)
    );

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] w;
        logic        bl;
        logic        ml;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ex;
    int          n_chk = 0, n_pass = 0;
    int          rmode = 0;  // 0: ready high, 1: toggle, 2: random
    bit          tail = 0, prev_stall = 0;
    logic [33:0] prev_out;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: standard SHA-1 padding of a whole message, split into words.
    task automatic push_msg(input byte_q_t msg);
        byte_q_t     p;
        logic [63:0] bits;
        int          nw;
        p    = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nw = p.size() / 4;
        for (int i = 0; i < nw; i++) begin
            exp_t e;
            e.w  = {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
            e.bl = (i % 16) == 15;
            e.ml = (i == nw - 1);
            exp_q.push_back(e);
        end
    endtask

    // Output-ready pattern generator.
    initial forever begin
        @(posedge sys_clk); #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: scoreboard pops, stall hold, and tail-phase handshake rules.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            tail = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_word_hold", {out_blk_last, out_msg_last, out_word}, prev_out);
            end
            if (tail) begin
                check("pad_in_ready_low", in_ready, 0);
                check("pad_no_bubble", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got %h, scoreboard empty", out_word);
                end else begin
                    ex = exp_q.pop_front();
                    check("word", out_word, ex.w);
                    check("blk_last", out_blk_last, ex.bl);
                    check("msg_last", out_msg_last, ex.ml);
                    check("len_ovf", len_ovf, 0);
                end
                if (out_msg_last) tail = 0;
            end
            if (in_valid && in_ready && in_last) tail = 1;
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_blk_last, out_msg_last, out_word};
        end
    end

    // Called and returns at posedge+1; holds the beat until accepted.
    task automatic send_beat(input logic [7:0] d, input logic l, input logic e);
        int t = 0;
        bit acc = 0;
        in_data = d; in_last = l; in_empty = e; in_valid = 1'b1;
        while (!acc && t < 500) begin
            @(negedge sys_clk);
            if (in_ready) acc = 1;
            else t++;
            @(posedge sys_clk); #1;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
        end
        in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input bit term_beat, input bit noise);
        push_msg(msg);
        foreach (msg[i]) begin
            if (noise) begin
                repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
                if ($urandom_range(0, 7) == 0) send_beat(8'($urandom), 1'b0, 1'b1);
            end
            send_beat(msg[i], (i == msg.size() - 1) && !term_beat, 1'b0);
        end
        if (msg.size() == 0 || term_beat) send_beat(8'($urandom), 1'b1, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(posedge sys_clk); #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        @(negedge sys_clk);
        check("idle_after_msg", out_valid, 0);
        @(posedge sys_clk); #1;
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_outputs", {out_blk_last, out_msg_last, len_ovf, out_word}, 0);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check("rst_ready_gap", in_ready, 0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        check("rst_ready_up", in_ready, 1);
        @(posedge sys_clk); #1;
    endtask

    function automatic byte_q_t fill(input int n, input logic [7:0] v);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(v);
        return q;
    endfunction

    function automatic byte_q_t abc();
        byte_q_t q;
        q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
        return q;
    endfunction

    initial begin
        byte_q_t m;
        int      len;

        do_reset();

        rmode = 0;
        send_msg(abc(), 0, 0);            drain();
        m = {};
        send_msg(m, 0, 0);                drain();
        send_msg(fill(56, 8'h61), 0, 0);  drain();
        send_msg(fill(64, 8'h61), 0, 0);  drain();

        rmode = 1;
        send_msg(abc(), 0, 0);            drain();

        // Abort after 6 bytes: only the completed first word may appear.
        rmode = 0;
        m = {};
        for (int i = 0; i < 6; i++) m.push_back(8'($urandom));
        begin
            exp_t e;
            e.w = {m[0], m[1], m[2], m[3]}; e.bl = 1'b0; e.ml = 1'b0;
            exp_q.push_back(e);
        end
        foreach (m[i]) send_beat(m[i], 1'b0, 1'b0);
        repeat (2) begin @(posedge sys_clk); #1; end
        do_reset();
        check("abort_flush", exp_q.size(), 0);
        repeat (4) begin @(posedge sys_clk); #1; end
        send_msg(abc(), 0, 0);            drain();

        // Randomized messages, ready patterns, terminator styles and noise.
        for (int k = 0; k < 30; k++) begin
            rmode = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       len = 52 + $urandom_range(0, 12);
                default: len = $urandom_range(0, 130);
            endcase
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, $urandom_range(0, 1) == 1, 1);
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
